char_r: RTL and testbench

// Serial character receiver; the far end of the single-wire char link driven by our char transmitter.

---
 rtl/char_r.sv | 151 +++++++++++++++
 tb/tb_char_r.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_r.sv
// Serial character receiver: idle-high line, 1 start bit, 8 data bits MSB first, 1 stop bit.
// Emits each good character with a one-cycle valid pulse; a low stop bit raises a one-cycle frame error.
module char_r #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_char,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF   = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   char_q, char_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_WAIT_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // The shift register is pure data; a stale value is never exposed without a full frame.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        char_d  = char_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_WAIT_IDLE: begin
                if (i_rx) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (!i_rx) begin
                    idx_d = '0;
                    if (CNT_HALF == CNT_ZERO) begin
                        state_d = S_DATA;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = S_START;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            S_START: begin
                // Mid-bit recheck rejects short low glitches on the idle line.
                if (cnt_q == CNT_HALF) begin
                    if (i_rx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {shift_q[DATA_W-2:0], i_rx};
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (i_rx) begin
                        char_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // A low stop bit may be a stuck line; wait for idle before re-arming.
                        err_d   = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_WAIT_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign o_char      = char_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_char_r.sv
// Bench for char_r at one and four clocks per bit; frames are built from bytes and expected
// pulse timing is derived from the framing rules (stop sample at H + 9*CPB after the start edge).
module tb_char_r;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx1, rx4;
    logic [7:0] char1, char4;
    logic       v1, v4, e1, e4, b1, b4;

    always #5 clk = ~clk;

    char_r #(.CLKS_PER_BIT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx1),
        .o_char(char1), .o_valid(v1), .o_frame_err(e1), .o_busy(b1)
    );

    char_r #(.CLKS_PER_BIT(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx4),
        .o_char(char4), .o_valid(v4), .o_frame_err(e4), .o_busy(b4)
    );

    int checks = 0;
    int passed = 0;
    int sel    = 0;
    int cyc    = 0;

    logic [7:0] cc;
    logic       cv, ce, cb;
    assign cc = (sel != 0) ? char4 : char1;
    assign cv = (sel != 0) ? v4 : v1;
    assign ce = (sel != 0) ? e4 : e1;
    assign cb = (sel != 0) ? b4 : b1;

    // Observations gathered by the stimulus tasks
    int         n_valid, n_err, n_busy, at_valid, at_err, valid_cyc;
    logic [7:0] char_at;

    function automatic int exp_off();
        int c;
        c = (sel != 0) ? 4 : 1;
        return (c - 1) / 2 + 9 * c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic b);
        if (sel != 0) rx4 = b;
        else          rx1 = b;
    endtask

    task automatic clear_obs();
        n_valid = 0; n_err = 0; n_busy = 0;
        at_valid = -1; at_err = -1; valid_cyc = -1; char_at = 8'h00;
    endtask

    task automatic sample_obs(input int j);
        if (cv) begin
            n_valid++;
            if (n_valid == 1) begin
                at_valid  = j;
                char_at   = cc;
                valid_cyc = cyc;
            end
        end
        if (ce) begin
            n_err++;
            at_err = j;
        end
        if (cb) n_busy++;
    endtask

    task automatic hold(input logic b, input int n);
        clear_obs();
        for (int i = 0; i < n; i++) begin
            drive(b);
            step();
            sample_obs(i);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        int         c, j;
        fr = {1'b0, d, stop};
        c  = (sel != 0) ? 4 : 1;
        j  = 0;
        clear_obs();
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < c; k++) begin
                drive(fr[9-b]);
                step();
                sample_obs(j);
                j++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx1 = 1'b1; rx4 = 1'b1; sel = 0;
        step(); step();
        checks++; if (char1 !== 8'h00) $display("FAIL reset_char1 got %h want 00", char1); else passed++;
        checks++; if ({v1, e1, b1} !== 3'b000) $display("FAIL reset_flags1 got %b want 000", {v1, e1, b1}); else passed++;
        checks++; if (char4 !== 8'h00) $display("FAIL reset_char4 got %h want 00", char4); else passed++;
        checks++; if ({v4, e4, b4} !== 3'b000) $display("FAIL reset_flags4 got %b want 000", {v4, e4, b4}); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        sel = 0;
        hold(1'b1, 2);
        checks++; if (n_valid + n_err + n_busy !== 0) $display("FAIL idle_quiet got %0d want 0", n_valid + n_err + n_busy); else passed++;
        send_frame(8'hA5, 1'b1);
        checks++; if (n_valid !== 1) $display("FAIL a5_npulse got %0d want 1", n_valid); else passed++;
        checks++; if (at_valid !== exp_off()) $display("FAIL a5_latency got %0d want %0d", at_valid, exp_off()); else passed++;
        checks++; if (char_at !== 8'hA5) $display("FAIL a5_char got %h want a5", char_at); else passed++;
        checks++; if (n_err !== 0) $display("FAIL a5_err got %0d want 0", n_err); else passed++;
        checks++; if (n_busy !== exp_off()) $display("FAIL a5_busy got %0d want %0d", n_busy, exp_off()); else passed++;
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        sel = 0;
        send_frame(8'h3C, 1'b0);
        checks++; if (n_err !== 1 || at_err !== 9) $display("FAIL ferr_pulse got n=%0d at=%0d want n=1 at=9", n_err, at_err); else passed++;
        checks++; if (n_valid !== 0) $display("FAIL ferr_novalid got %0d want 0", n_valid); else passed++;
        checks++; if (cc !== 8'hA5) $display("FAIL ferr_char got %h want a5", cc); else passed++;
        hold(1'b0, 5);
        checks++; if (n_valid + n_err + n_busy !== 0) $display("FAIL ferr_stuck_quiet got %0d want 0", n_valid + n_err + n_busy); else passed++;
        checks++; if (cc !== 8'hA5) $display("FAIL ferr_char_hold got %h want a5", cc); else passed++;
        hold(1'b1, 1);
        d = 8'($urandom);
        send_frame(d, 1'b1);
        checks++; if (n_valid !== 1 || char_at !== d) $display("FAIL ferr_recover got n=%0d char=%h want n=1 char=%h", n_valid, char_at, d); else passed++;
    endtask

    task automatic test_stuck_low();
        sel = 0;
        rx1 = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
        hold(1'b0, 20);
        checks++; if (n_valid + n_err + n_busy !== 0) $display("FAIL stuck_quiet got %0d want 0", n_valid + n_err + n_busy); else passed++;
        checks++; if (cc !== 8'h00) $display("FAIL stuck_char got %h want 00", cc); else passed++;
        hold(1'b1, 1);
        send_frame(8'h5A, 1'b1);
        checks++; if (n_valid !== 1 || char_at !== 8'h5A) $display("FAIL stuck_5a got n=%0d char=%h want n=1 char=5a", n_valid, char_at); else passed++;
        checks++; if (at_valid !== 9) $display("FAIL stuck_5a_latency got %0d want 9", at_valid); else passed++;
    endtask

    task automatic test_glitch_cpb4();
        int pulses;
        sel = 1;
        hold(1'b1, 2);
        hold(1'b0, 1);
        pulses = n_valid + n_err;
        hold(1'b1, 1);
        pulses += n_valid + n_err;
        checks++; if (cb !== 1'b0) $display("FAIL glitch_busy got %b want 0", cb); else passed++;
        checks++; if (pulses !== 0) $display("FAIL glitch_pulses got %0d want 0", pulses); else passed++;
        hold(1'b1, 2);
        send_frame(8'h81, 1'b1);
        checks++; if (n_valid !== 1 || char_at !== 8'h81) $display("FAIL cpb4_81 got n=%0d char=%h want n=1 char=81", n_valid, char_at); else passed++;
        checks++; if (at_valid !== 37) $display("FAIL cpb4_latency got %0d want 37", at_valid); else passed++;
        checks++; if (n_busy !== 37) $display("FAIL cpb4_busy got %0d want 37", n_busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int         first_cyc;
        logic [7:0] d;
        sel = 0;
        send_frame(8'h00, 1'b1);
        first_cyc = valid_cyc;
        checks++; if (n_valid !== 1 || char_at !== 8'h00) $display("FAIL b2b_00 got n=%0d char=%h want n=1 char=00", n_valid, char_at); else passed++;
        send_frame(8'hFF, 1'b1);
        checks++; if (n_valid !== 1 || char_at !== 8'hFF) $display("FAIL b2b_ff got n=%0d char=%h want n=1 char=ff", n_valid, char_at); else passed++;
        checks++; if (valid_cyc - first_cyc !== 10) $display("FAIL b2b_gap got %0d want 10", valid_cyc - first_cyc); else passed++;
        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            hold(1'b1, int'($urandom_range(0, 2)));
            d = 8'($urandom);
            send_frame(d, 1'b1);
            checks++;
            if (n_valid !== 1 || char_at !== d || at_valid !== exp_off() || n_err !== 0)
                $display("FAIL rand_frame%0d cpb_sel=%0d got n=%0d char=%h at=%0d err=%0d want n=1 char=%h at=%0d err=0",
                         i, sel, n_valid, char_at, at_valid, n_err, d, exp_off());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        logic [7:0] d;
        sel = 0;
        hold(1'b1, 1);
        fr = {1'b0, 8'hC3, 1'b1};
        for (int b = 0; b < 5; b++) begin
            drive(fr[9-b]);
            step();
        end
        checks++; if (cb !== 1'b1) $display("FAIL mid_busy_before got %b want 1", cb); else passed++;
        drive(fr[4]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({char1, v1, e1, b1} !== 11'h000) $display("FAIL mid_reset_outs got char=%h v=%b e=%b b=%b want all 0", char1, v1, e1, b1); else passed++;
        hold(1'b0, 3);
        checks++; if (n_valid + n_err + n_busy !== 0) $display("FAIL mid_rearm_quiet got %0d want 0", n_valid + n_err + n_busy); else passed++;
        hold(1'b1, 1);
        d = 8'($urandom);
        send_frame(d, 1'b1);
        checks++; if (n_valid !== 1 || char_at !== d) $display("FAIL mid_recover got n=%0d char=%h want n=1 char=%h", n_valid, char_at, d); else passed++;
    endtask

    initial begin
        rst = 1'b1; rx1 = 1'b1; rx4 = 1'b1;
        test_reset();
        test_good_frame();
        test_frame_err();
        test_stuck_low();
        test_glitch_cpb4();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
